mcpu_ctrl: RTL and testbench
============================

# mcpu_ctrl

Parametrised multi-cycle control unit for the MIPS-subset CPU. It decodes the instruction held in IR and sequences fetch, decode, execute, memory and writeback as a state machine, driving every enable and mux select of the multi-cycle datapath. Compared with the single-cycle-memory control LUT, it adds:
- a request/ready handshake for variable-latency memory;
- `jal`/`jr` support;
- a sticky illegal-instruction trap;
- retired-instruction and cycle counters.

## Interface
Parameters:
- `MEM_HANDSHAKE`, default 1: 1 = wait on `mem_ready`; 0 = treat `mem_ready` as constant 1.
- `PERF_W`, default 32: width of `cycle_count` and `instr_count`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `instr` in 32: IR output.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: memory write enable.
- `mem_addr_sel` out 1: memory address source; 0 = PC, 1 = ALU reg.
- `pc_we`, `ir_we`, `a_we`, `b_we`, `reg_we` out 1 each: register enables.
- `reg_dst` out 2: register write address; 0 = rd, 1 = rt, 2 = r31.
- `mem_to_reg` out 2: register write data; 0 = ALU reg, 1 = MDR, 2 = PC.
- `alu_src_a` out 2: 0 = PC, 1 = A.
- `alu_src_b` out 2: 0 = imm32<<2, 1 = imm32, 2 = B, 3 = 4.
- `alu_op` out 3: ADD = 0, SUB = 1, XOR = 2, SLT = 3.
- `pc_src` out 2: 0 = live ALU result, 1 = jump concat, 2 = ALU reg, 3 = A.
- `state` out 4: current state encoding.
- `illegal` out 1: trap flag.
- `retire` out 1: one-cycle pulse when an instruction completes.
- `cycle_count` out `PERF_W`: cycle counter.
- `instr_count` out `PERF_W`: retired-instruction counter.

## Operation
- Decode uses opcode `instr[31:26]` and funct `instr[5:0]`.
- Legal instructions:
  - R-type (opcode 0x00): add (funct 0x20), sub (0x22), slt (0x2A), jr (0x08).
  - I-type and jumps: lw 0x23, sw 0x2B, addi 0x08, xori 0x0E, beq 0x04, bne 0x05, j 0x02, jal 0x03.
- Any other opcode/funct combination is illegal.
- Signals not listed for a state are 0 (selects 0). State encodings in brackets.
- FETCH [0]:
  - Drive `mem_req`=1, `mem_addr_sel`=0, `alu_src_a`=0, `alu_src_b`=3, ADD, `pc_src`=0.
  - `ir_we` and `pc_we` are 1 only in a cycle with `mem_ready`=1. That cycle loads PC+4 and goes to DECODE; otherwise stay in FETCH.
- DECODE [1]:
  - `a_we`=`b_we`=1; `alu_src_a`=0, `alu_src_b`=0, ADD, so the ALU reg captures the branch target.
  - Next state by decode: EXEC_R, EXEC_I, MEM_ADDR, BRANCH, JUMP, JAL, JR, or ILLEGAL.
- EXEC_R [2]: A op B, with `alu_op` from funct (add → ADD, sub → SUB, slt → SLT). Next: WB_R.
- WB_R [3]: `reg_we`=1, `reg_dst`=0, `mem_to_reg`=0. Retire, then FETCH.
- EXEC_I [4]: A op imm32 (ADD for addi, XOR for xori). Next: WB_I.
- WB_I [5]: `reg_we`=1, `reg_dst`=1, `mem_to_reg`=0. Retire, then FETCH.
- MEM_ADDR [6]: A + imm32. Next: MEM_RD for lw, MEM_WR for sw.
- MEM_RD [7]: `mem_req`=1, `mem_addr_sel`=1. Wait for `mem_ready`; the MDR captures data on the ready edge. Next: MEM_WB.
- MEM_WB [8]: `reg_we`=1, `reg_dst`=1, `mem_to_reg`=1. Retire, then FETCH.
- MEM_WR [9]: `mem_req`=`mem_we`=1, `mem_addr_sel`=1. Wait for `mem_ready`, then retire and go to FETCH.
- BRANCH [10]:
  - A SUB B; taken = `zero` XOR (opcode == bne).
  - `pc_we`=taken, `pc_src`=2. Retire, then FETCH.
- JUMP [11]: `pc_we`=1, `pc_src`=1. Retire, then FETCH.
- JAL [12]:
  - JUMP signals plus `reg_we`=1, `reg_dst`=2, `mem_to_reg`=2.
  - r31 receives the pre-update PC, which already equals PC+4. Retire, then FETCH.
- JR [13]: `pc_we`=1, `pc_src`=3. Retire, then FETCH.
- ILLEGAL [15]:
  - All enables 0, `illegal`=1.
  - Sticky until reset; counters freeze.
- Counters:
  - `cycle_count` increments every cycle outside reset and ILLEGAL.
  - `instr_count` increments on each `retire`.
  - Both wrap modulo 2^`PERF_W`.

## Timing
- Reset:
  - `state` returns to FETCH asynchronously; counters and `illegal` are 0.
  - While `reset` is high, all enables, `mem_req`, and `retire` are forced to 0.
  - Reset mid-access abandons the request: `mem_req` drops immediately.
- Outputs are combinational from `state`. Mealy terms are limited to:
  - `mem_ready` gating `ir_we`/`pc_we`/`retire`/transitions in FETCH, MEM_RD and MEM_WR;
  - `zero` gating `pc_we` in BRANCH.
- Zero-wait latency in cycles, FETCH through retire inclusive: R 4, addi/xori 4, lw 5, sw 4, beq/bne 3, j/jal/jr 3.
- Each wait cycle in FETCH, MEM_RD or MEM_WR adds exactly 1 cycle.
- `mem_req`, `mem_addr_sel` and `mem_we` hold stable while waiting.

## Test plan
- Reset check: assert `reset` mid-MEM_RD with `mem_ready`=0 → `state`=0, `mem_req`=0, counters 0 in the same cycle. Deassert → FETCH with `mem_req`=1.
- add, `instr`=0x014B4820, `mem_ready`=1 → states 0,1,2,3. In state 3: `reg_we`=1, `reg_dst`=0. `retire` pulses once; `instr_count`=1, `cycle_count`=4.
- lw, 0x8D090004, with `mem_ready` held low for 2 cycles in MEM_RD → 7 cycles total. `mem_addr_sel`=1 and `mem_req`=1 stable throughout the wait; MEM_WB has `mem_to_reg`=1.
- bne, 0x15090003:
  - with `zero`=1 → `pc_we`=0;
  - rerun with `zero`=0 → `pc_we`=1, `pc_src`=2.
  - Both runs take 3 cycles.
- jal, 0x0C000010 → in state 12: `pc_we`=1, `pc_src`=1, `reg_we`=1, `reg_dst`=2, `mem_to_reg`=2. Then jr r31, 0x03E00008 → `pc_src`=3.
- Opcode 0x3F → DECODE goes to state 15, `illegal`=1. `pc_we`=0 and `cycle_count` frozen for 10 cycles; cleared only by `reset`.

Source files
------------

// File: rtl/mcpu_ctrl.sv
// Multi-cycle control unit for the MIPS-subset CPU: decodes IR, sequences the datapath
// through fetch/decode/execute/memory/writeback and keeps cycle and retire counters.
module mcpu_ctrl #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int PERF_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_addr_sel,
    output logic              pc_we,
    output logic              ir_we,
    output logic              a_we,
    output logic              b_we,
    output logic              reg_we,
    output logic [1:0]        reg_dst,
    output logic [1:0]        mem_to_reg,
    output logic [1:0]        alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [2:0]        alu_op,
    output logic [1:0]        pc_src,
    output logic [3:0]        state,
    output logic              illegal,
    output logic              retire,
    output logic [PERF_W-1:0] cycle_count,
    output logic [PERF_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL      = 4'd12,
        S_JR       = 4'd13,
        S_ILLEGAL  = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_LW   = 6'h23, OP_SW  = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08, OP_XORI = 6'h0E, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05, OP_J    = 6'h02, OP_JAL = 6'h03;
    localparam logic [5:0] FN_ADD   = 6'h20, FN_SUB  = 6'h22, FN_SLT = 6'h2A, FN_JR = 6'h08;

    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_XOR = 3'd2, ALU_SLT = 3'd3;

    state_t            state_q, state_d;
    logic [PERF_W-1:0] cycle_q, cycle_d;
    logic [PERF_W-1:0] icnt_q, icnt_d;

    logic [5:0] opcode, funct;
    logic       rdy;
    logic       unused_instr_bits;

    assign opcode            = instr[31:26];
    assign funct             = instr[5:0];
    assign rdy               = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign unused_instr_bits = ^instr[25:6];

    function automatic state_t decode_target(input logic [5:0] op, input logic [5:0] fn);
        state_t t;
        t = S_ILLEGAL;
        case (op)
            OP_RTYPE: begin
                if (fn == FN_ADD || fn == FN_SUB || fn == FN_SLT) t = S_EXEC_R;
                else if (fn == FN_JR)                            t = S_JR;
            end
            OP_LW, OP_SW:     t = S_MEM_ADDR;
            OP_ADDI, OP_XORI: t = S_EXEC_I;
            OP_BEQ, OP_BNE:   t = S_BRANCH;
            OP_J:             t = S_JUMP;
            OP_JAL:           t = S_JAL;
            default:          t = S_ILLEGAL;
        endcase
        return t;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            cycle_q <= '0;
            icnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cycle_q <= cycle_d;
            icnt_q  <= icnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = rdy ? S_DECODE : S_FETCH;
            S_DECODE:   state_d = decode_target(opcode, funct);
            S_EXEC_R:   state_d = S_WB_R;
            S_EXEC_I:   state_d = S_WB_I;
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = rdy ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   state_d = rdy ? S_FETCH : S_MEM_WR;
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        pc_we        = 1'b0;
        ir_we        = 1'b0;
        a_we         = 1'b0;
        b_we         = 1'b0;
        reg_we       = 1'b0;
        reg_dst      = 2'd0;
        mem_to_reg   = 2'd0;
        alu_src_a    = 2'd0;
        alu_src_b    = 2'd0;
        alu_op       = ALU_ADD;
        pc_src       = 2'd0;
        illegal      = 1'b0;
        retire       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd3;
                ir_we     = rdy;
                pc_we     = rdy;
            end
            S_DECODE: begin
                a_we = 1'b1;
                b_we = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                if (funct == FN_SUB)      alu_op = ALU_SUB;
                else if (funct == FN_SLT) alu_op = ALU_SLT;
            end
            S_WB_R: begin
                reg_we = 1'b1;
                retire = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                alu_op    = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
            end
            S_WB_I: begin
                reg_we  = 1'b1;
                reg_dst = 2'd1;
                retire  = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
            end
            S_MEM_RD: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
            end
            S_MEM_WB: begin
                reg_we     = 1'b1;
                reg_dst    = 2'd1;
                mem_to_reg = 2'd1;
                retire     = 1'b1;
            end
            S_MEM_WR: begin
                mem_req      = 1'b1;
                mem_we       = 1'b1;
                mem_addr_sel = 1'b1;
                retire       = rdy;
            end
            S_BRANCH: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                alu_op    = ALU_SUB;
                pc_src    = 2'd2;
                pc_we     = zero ^ (opcode == OP_BNE);
                retire    = 1'b1;
            end
            S_JUMP: begin
                pc_we  = 1'b1;
                pc_src = 2'd1;
                retire = 1'b1;
            end
            // r31 takes the PC register directly: it was already advanced to PC+4 in FETCH.
            S_JAL: begin
                pc_we      = 1'b1;
                pc_src     = 2'd1;
                reg_we     = 1'b1;
                reg_dst    = 2'd2;
                mem_to_reg = 2'd2;
                retire     = 1'b1;
            end
            S_JR: begin
                pc_we  = 1'b1;
                pc_src = 2'd3;
                retire = 1'b1;
            end
            S_ILLEGAL: illegal = 1'b1;
            default: ;
        endcase
        if (reset) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            pc_we   = 1'b0;
            ir_we   = 1'b0;
            a_we    = 1'b0;
            b_we    = 1'b0;
            reg_we  = 1'b0;
            retire  = 1'b0;
        end
    end

    always_comb begin
        cycle_d = (state_q != S_ILLEGAL) ? cycle_q + 1'b1 : cycle_q;
        icnt_d  = icnt_q + {{(PERF_W-1){1'b0}}, retire};
    end

    assign state       = state_q;
    assign cycle_count = cycle_q;
    assign instr_count = icnt_q;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Bench for mcpu_ctrl: table of zero-wait instructions, hand-written reset/wait/trap
// sequences, and random instruction streams with random memory stalls.
module tb_mcpu_ctrl;

    logic        clk = 1'b0;
    logic        reset, zero, mem_ready;
    logic [31:0] instr;
    logic        mem_req, mem_we, mem_addr_sel, pc_we, ir_we, a_we, b_we, reg_we;
    logic [1:0]  reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src;
    logic [2:0]  alu_op;
    logic [3:0]  state;
    logic        illegal, retire;
    logic [31:0] cycle_count, instr_count;

    mcpu_ctrl #(.MEM_HANDSHAKE(1), .PERF_W(32)) dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .pc_we(pc_we), .ir_we(ir_we), .a_we(a_we), .b_we(b_we), .reg_we(reg_we),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .state(state),
        .illegal(illegal), .retire(retire), .cycle_count(cycle_count),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Leaves the bench at a falling edge with the first FETCH cycle in progress.
    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        zero = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [31:0] ins;
        logic        z;
        int          lat;
        logic [3:0]  st;
        logic        pcwe;
        logic [1:0]  src;
        logic        rwe;
        logic [1:0]  dst;
        logic [1:0]  m2r;
        logic        mwe;
        logic [2:0]  op3;
        logic [1:0]  sa3;
        logic [1:0]  sb3;
    } vec_t;

    localparam int NT = 15;
    vec_t tbl [NT];

    initial begin #500000; $display("FAIL watchdog: bench did not finish"); $fatal(1); end

    initial begin
        logic       got;
        logic       rdy_pat [7];
        logic [3:0] st_pat  [7];
        logic [31:0] legal_base [12];
        logic [3:0] es [$];
        logic       er [$];
        logic       z;
        int         k, fw, mw, mc, mi;
        logic [31:0] frozen;

        instr = 32'h0;
        //              ins         z  lat st  pcwe src rwe dst m2r mwe op3 sa3 sb3
        tbl[0]  = '{32'h014B4820, 0, 4, 3,  0, 0, 1, 0, 0, 0, 0, 1, 2};  // add
        tbl[1]  = '{32'h014B4822, 0, 4, 3,  0, 0, 1, 0, 0, 0, 1, 1, 2};  // sub
        tbl[2]  = '{32'h014B482A, 0, 4, 3,  0, 0, 1, 0, 0, 0, 3, 1, 2};  // slt
        tbl[3]  = '{32'h21090005, 0, 4, 5,  0, 0, 1, 1, 0, 0, 0, 1, 1};  // addi
        tbl[4]  = '{32'h3909FFFF, 0, 4, 5,  0, 0, 1, 1, 0, 0, 2, 1, 1};  // xori
        tbl[5]  = '{32'h8D090004, 0, 5, 8,  0, 0, 1, 1, 1, 0, 0, 1, 1};  // lw
        tbl[6]  = '{32'hAD090004, 0, 4, 9,  0, 0, 0, 0, 0, 1, 0, 1, 1};  // sw
        tbl[7]  = '{32'h11090003, 1, 3, 10, 1, 2, 0, 0, 0, 0, 1, 1, 2};  // beq taken
        tbl[8]  = '{32'h11090003, 0, 3, 10, 0, 2, 0, 0, 0, 0, 1, 1, 2};  // beq not taken
        tbl[9]  = '{32'h15090003, 1, 3, 10, 0, 2, 0, 0, 0, 0, 1, 1, 2};  // bne not taken
        tbl[10] = '{32'h15090003, 0, 3, 10, 1, 2, 0, 0, 0, 0, 1, 1, 2};  // bne taken
        tbl[11] = '{32'h08000010, 0, 3, 11, 1, 1, 0, 0, 0, 0, 0, 0, 0};  // j
        tbl[12] = '{32'h0C000010, 0, 3, 12, 1, 1, 1, 2, 2, 0, 0, 0, 0};  // jal
        tbl[13] = '{32'h03E00008, 0, 3, 13, 1, 3, 0, 0, 0, 0, 0, 0, 0};  // jr r31
        tbl[14] = '{32'h02B6A020, 1, 4, 3,  0, 0, 1, 0, 0, 0, 0, 1, 2};  // add, zero ignored

        do_reset();
        #1;
        chk("reset outputs", {state, mem_req, illegal, cycle_count, instr_count}, {4'd0, 1'b1, 1'b0, 64'h0});
        reset = 1'b1;
        #1;
        chk("in reset gating", {state, mem_req, ir_we, pc_we, retire}, {4'd0, 4'b0});

        for (int i = 0; i < NT; i++) begin
            do_reset();
            instr = tbl[i].ins;
            got = 1'b0;
            for (int c = 1; c <= 12 && !got; c++) begin
                mem_ready = 1'b1;
                zero = tbl[i].z;
                #1;
                if (c == 1) chk("fetch outs", {state, mem_req, ir_we, pc_we, alu_src_b, pc_src}, {4'd0, 3'b111, 2'd3, 2'd0});
                if (c == 2) chk("decode outs", {state, a_we, b_we, alu_src_a, alu_src_b}, {4'd1, 2'b11, 2'd0, 2'd0});
                if (c == 3) chk("cycle3 alu", {alu_op, alu_src_a, alu_src_b}, {tbl[i].op3, tbl[i].sa3, tbl[i].sb3});
                if (retire) begin
                    got = 1'b1;
                    chk("latency", c, tbl[i].lat);
                    chk("retire outs", {state, pc_we, pc_src, reg_we, reg_dst, mem_to_reg, mem_we},
                        {tbl[i].st, tbl[i].pcwe, tbl[i].src, tbl[i].rwe, tbl[i].dst, tbl[i].m2r, tbl[i].mwe});
                end
                @(negedge clk);
            end
            chk("retire seen", got, 1'b1);
            #1;
            chk("counters", {cycle_count, instr_count}, {tbl[i].lat, 32'd1});
        end

        // lw with two stall cycles in MEM_RD
        do_reset();
        instr = 32'h8D090004;
        rdy_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        st_pat  = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd7, 4'd7, 4'd8};
        for (int c = 0; c < 7; c++) begin
            mem_ready = rdy_pat[c];
            #1;
            chk("lw state", state, st_pat[c]);
            if (c >= 3 && c <= 5) chk("lw wait outs", {mem_req, mem_addr_sel, mem_we, retire}, 4'b1100);
            if (c == 6) chk("lw writeback", {mem_to_reg, reg_we, reg_dst, retire}, {2'd1, 1'b1, 2'd1, 1'b1});
            @(negedge clk);
        end
        #1;
        chk("lw counters", {cycle_count, instr_count}, {32'd7, 32'd1});

        // Reset asserted mid MEM_RD abandons the request at once
        do_reset();
        instr = 32'h8D090004;
        rdy_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int c = 0; c < 4; c++) begin
            mem_ready = rdy_pat[c];
            #1;
            if (c < 3) @(negedge clk);
        end
        chk("pre-reset mem_rd", {state, mem_req, mem_addr_sel}, {4'd7, 2'b11});
        reset = 1'b1;
        #1;
        chk("async reset", {state, mem_req, cycle_count, instr_count}, {4'd0, 1'b0, 64'h0});
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("after reset", {state, mem_req, mem_addr_sel}, {4'd0, 2'b10});

        // Illegal opcode traps and freezes the counters
        do_reset();
        instr = 32'hFC000000;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("trap entry", {state, illegal}, {4'd15, 1'b1});
        frozen = 32'd2;
        for (int c = 0; c < 10; c++) begin
            mem_ready = c[0];
            #1;
            chk("trap hold", {state, illegal, pc_we, ir_we, mem_req, reg_we, retire, cycle_count},
                {4'd15, 1'b1, 5'b0, frozen});
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        chk("trap cleared", {state, illegal, cycle_count, instr_count}, {4'd0, 1'b0, 64'h0});
        @(negedge clk);
        reset = 1'b0;

        // Unknown R-type funct also traps
        do_reset();
        instr = 32'h014B4821;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("bad funct trap", {state, illegal}, {4'd15, 1'b1});

        // Random streams against a state-path model with random stalls
        legal_base = '{32'h00000020, 32'h00000022, 32'h0000002A, 32'h00000008,
                       32'h8C000000, 32'hAC000000, 32'h20000000, 32'h38000000,
                       32'h10000000, 32'h14000000, 32'h08000000, 32'h0C000000};
        do_reset();
        mc = 0;
        mi = 0;
        for (int n = 0; n < 200; n++) begin
            k  = $urandom_range(0, 11);
            fw = $urandom_range(0, 2);
            mw = $urandom_range(0, 2);
            z  = 1'($urandom_range(0, 1));
            if (k <= 3) instr = legal_base[k] | ($urandom & 32'h03FFFFC0);
            else        instr = legal_base[k] | ($urandom & 32'h03FFFFFF);
            es.delete();
            er.delete();
            repeat (fw) begin es.push_back(4'd0); er.push_back(1'b0); end
            es.push_back(4'd0); er.push_back(1'b1);
            es.push_back(4'd1); er.push_back(1'($urandom_range(0, 1)));
            case (k)
                0, 1, 2: begin es.push_back(4'd2); es.push_back(4'd3); end
                3:       es.push_back(4'd13);
                4: begin
                    es.push_back(4'd6); er.push_back(1'($urandom_range(0, 1)));
                    repeat (mw) begin es.push_back(4'd7); er.push_back(1'b0); end
                    es.push_back(4'd7); er.push_back(1'b1);
                    es.push_back(4'd8);
                end
                5: begin
                    es.push_back(4'd6); er.push_back(1'($urandom_range(0, 1)));
                    repeat (mw) begin es.push_back(4'd9); er.push_back(1'b0); end
                    es.push_back(4'd9); er.push_back(1'b1);
                end
                6, 7:    begin es.push_back(4'd4); es.push_back(4'd5); end
                8, 9:    es.push_back(4'd10);
                10:      es.push_back(4'd11);
                default: es.push_back(4'd12);
            endcase
            while (er.size() < es.size()) er.push_back(1'($urandom_range(0, 1)));
            for (int j = 0; j < es.size(); j++) begin
                mem_ready = er[j];
                zero = z;
                #1;
                chk("rnd state", state, es[j]);
                chk("rnd retire", retire, (j == es.size() - 1));
                chk("rnd mem_req", mem_req, (es[j] == 4'd0 || es[j] == 4'd7 || es[j] == 4'd9));
                if (k == 8 || k == 9)
                    if (j == es.size() - 1) chk("rnd branch pc_we", pc_we, z ^ (k == 9));
                @(negedge clk);
            end
            mc += es.size();
            mi++;
            chk("rnd counters", {cycle_count, instr_count}, {mc[31:0], mi[31:0]});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
